alu_resp64: RTL and testbench

Registered 64-bit ALU responder for the execute stage. It accepts an operand pair and a function code over a valid/ready request channel and computes add, sub, and, or xor. It returns the result with Y86-style condition flags (OF, ZF, SF) over a valid/ready response channel. It is the responding end of the in1/in2 → out/OF_FLAG operand interface that benches and the fetch/decode side drive.

---
 rtl/alu_pkg.sv | 11 +
 rtl/alu_core64.sv | 26 ++
 rtl/alu_resp64.sv | 64 ++++++
 tb/tb_alu_resp64.sv | 124 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared function codes, FSM encoding and default width for the 64-bit ALU responder.
package alu_pkg;
  localparam int ALU_WIDTH = 64;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_EXEC = 2'b01;
  localparam logic [1:0] S_RESP = 2'b10;
endpackage

// File: rtl/alu_core64.sv
// alu_core64: combinational add/sub/and/xor with Y86-style OF/ZF/SF flags.
module alu_core64
  import alu_pkg::*;
#(
  parameter int W = ALU_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   fn,
  output logic [W-1:0] y,
  output logic         of,
  output logic         zf,
  output logic         sf
);
  logic [W-1:0] sum, diff;
  assign sum  = a + b;
  assign diff = a - b;
  assign y  = fn == ALU_ADD ? sum :
              fn == ALU_SUB ? diff :
              fn == ALU_AND ? (a & b) : (a ^ b);
  // overflow only when the result sign disagrees with what same/opposite-signed operands allow
  assign of = fn == ALU_ADD ? (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]) :
              fn == ALU_SUB ? (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]) : 1'b0;
  assign zf = y == '0;
  assign sf = y[W-1];
endmodule

// File: rtl/alu_resp64.sv
// alu_resp64: registered ALU responder; captures a request, computes one cycle later,
// holds the result until the consumer accepts it, then latches the condition codes.
module alu_resp64 #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       alu_fn,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] out,
  output logic             OF_FLAG,
  output logic             ZF_FLAG,
  output logic             SF_FLAG,
  output logic [2:0]       cc
);
  import alu_pkg::*;
  logic [1:0]       state;
  logic [WIDTH-1:0] a_q, b_q, y;
  logic [1:0]       fn_q;
  logic             of, zf, sf;
  alu_core64 #(.W(WIDTH)) u_core (
    .a(a_q), .b(b_q), .fn(fn_q), .y(y), .of(of), .zf(zf), .sf(sf)
  );
  assign req_ready = state == S_IDLE && !rst;
  assign rsp_valid = state == S_RESP;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      fn_q    <= ALU_ADD;
      out     <= '0;
      OF_FLAG <= 1'b0;
      ZF_FLAG <= 1'b0;
      SF_FLAG <= 1'b0;
      cc      <= 3'b000;
    end else if (state == S_IDLE) begin
      if (req_valid) begin
        a_q   <= in1;
        b_q   <= in2;
        fn_q  <= alu_fn;
        state <= S_EXEC;
      end
    end else if (state == S_EXEC) begin
      out     <= y;
      OF_FLAG <= of;
      ZF_FLAG <= zf;
      SF_FLAG <= sf;
      state   <= S_RESP;
    end else if (state == S_RESP) begin
      if (rsp_ready) begin
        cc    <= {ZF_FLAG, SF_FLAG, OF_FLAG};
        state <= S_IDLE;
      end
    end else begin
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_alu_resp64.sv
// tb_alu_resp64: directed scoreboard bench for the registered ALU responder.
module tb_alu_resp64;
  typedef struct {
    logic [63:0] y;
    logic        of, zf, sf;
  } exp_t;
  logic        clk = 0, rst = 0, req_valid = 0, rsp_ready = 0;
  logic [63:0] in1 = '0, in2 = '0;
  logic [1:0]  alu_fn = '0;
  logic        req_ready, rsp_valid, OF_FLAG, ZF_FLAG, SF_FLAG;
  logic [63:0] out;
  logic [2:0]  cc;
  logic [2:0]  last_cc = 3'b000;
  exp_t        sb[$];
  int          n_tests = 0, n_fail = 0;
  alu_resp64 dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .in1(in1), .in2(in2), .alu_fn(alu_fn), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .out(out), .OF_FLAG(OF_FLAG), .ZF_FLAG(ZF_FLAG), .SF_FLAG(SF_FLAG), .cc(cc)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed running, expected finished");
    $fatal(1, "watchdog");
  end
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic [1:0] fn);
    exp_t e;
    logic [64:0] x;
    x = 65'd0;
    if (fn == 2'b00) x = {a[63], a} + {b[63], b};
    if (fn == 2'b01) x = {a[63], a} - {b[63], b};
    if (fn == 2'b10) x = {1'b0, a & b};
    if (fn == 2'b11) x = {1'b0, a ^ b};
    e.y  = x[63:0];
    e.of = fn[1] ? 1'b0 : (x[64] != x[63]);
    e.zf = e.y == 64'd0;
    e.sf = e.y[63];
    return e;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] fn, input int hold);
    exp_t e;
    int n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1; in1 = a; in2 = b; alu_fn = fn;
    rsp_ready = 1'($urandom);
    step();
    sb.push_back(model(a, b, fn));
    req_valid = 0; in1 = 64'($urandom); in2 = ~a; alu_fn = ~fn;
    rsp_ready = (hold == 0);
    chk({tag, "_exec_valid"}, {62'd0, req_ready, rsp_valid}, 64'd0);
    step();
    chk({tag, "_rsp_valid"}, {62'd0, req_ready, rsp_valid}, 64'd1);
    chk({tag, "_sb_size"}, 64'(sb.size()), 64'd1);
    e = (sb.size() != 0) ? sb.pop_front() : model(a, b, fn);
    chk({tag, "_out"}, out, e.y);
    chk({tag, "_flags"}, {61'd0, OF_FLAG, ZF_FLAG, SF_FLAG}, {61'd0, e.of, e.zf, e.sf});
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_cc_held"}, 64'(cc), 64'(last_cc));
      step();
      chk({tag, "_hold_out"}, out, e.y);
      chk({tag, "_hold_hs"}, {62'd0, req_ready, rsp_valid}, 64'd1);
    end
    rsp_ready = 1;
    chk({tag, "_cc_pre"}, 64'(cc), 64'(last_cc));
    step();
    last_cc = {e.zf, e.sf, e.of};
    chk({tag, "_cc"}, 64'(cc), 64'(last_cc));
    chk({tag, "_idle"}, {62'd0, req_ready, rsp_valid}, 64'd2);
    rsp_ready = 0;
  endtask
  initial begin
    #3 rst = 1;
    #1;
    chk("reset_out", out, 64'd0);
    chk("reset_flags_cc", {58'd0, OF_FLAG, ZF_FLAG, SF_FLAG, cc}, 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    step(); step();
    rst = 0;
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    step();
    do_op("xor", 64'h26, 64'h31, 2'b11, 0);
    do_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 0);
    do_op("sub_zero", 64'(-45), 64'(-45), 2'b01, 0);
    do_op("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 2'b01, 0);
    do_op("and_bp", 64'(-33), 64'(-34), 2'b10, 4);
    do_op("add_plain", 64'd100, 64'(-7), 2'b00, 1);
    // reset during EXEC must drop the operation entirely
    req_valid = 1; in1 = 64'd5; in2 = 64'd6; alu_fn = 2'b00;
    step();
    req_valid = 0;
    #2 rst = 1;
    #1;
    chk("rst_exec_cc", 64'(cc), 64'd0);
    chk("rst_exec_valid", 64'(rsp_valid), 64'd0);
    step();
    rst = 0;
    last_cc = 3'b000;
    rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_exec_no_rsp", 64'(rsp_valid), 64'd0);
    end
    rsp_ready = 0;
    do_op("after_rst", 64'd0, 64'd0, 2'b11, 0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
